// File: rtl/nco_phase_sweep.sv
// nco_phase_sweep: modulo-2^PHASE_BITS phase accumulator with offset, linear chirp and counted or continuous runs
module nco_phase_sweep #(
  parameter int PHASE_BITS = 47,
  parameter int CNT_BITS = 32
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  start_i,
  input  logic                  stop_i,
  input  logic [PHASE_BITS-1:0] ftw_i,
  input  logic [PHASE_BITS-1:0] step_i,
  input  logic [PHASE_BITS-1:0] poff_i,
  input  logic [CNT_BITS-1:0]   nsamp_i,
  output logic                  valid_o,
  output logic [PHASE_BITS-1:0] phase_o,
  output logic                  busy_o,
  output logic                  done_o
);
  typedef enum logic {IDLE, RUN} state_t;
  state_t state;
  logic [PHASE_BITS-1:0] acc, freq, step, poff;
  logic [CNT_BITS-1:0] cnt;
  // run control: latch config on start, issue one wrapped sample per cycle, end on count or stop
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      state <= IDLE;
      valid_o <= 1'b0;
      phase_o <= '0;
      busy_o <= 1'b0;
      done_o <= 1'b0;
      acc <= '0;
      freq <= '0;
      step <= '0;
      poff <= '0;
      cnt <= '0;
    end else if (state == IDLE) begin
      valid_o <= 1'b0;
      busy_o <= 1'b0;
      done_o <= 1'b0;
      if (start_i && !stop_i) begin
        freq <= ftw_i;
        step <= step_i;
        poff <= poff_i;
        cnt <= nsamp_i;
        acc <= '0;
        state <= RUN;
      end
    end else if (stop_i) begin
      valid_o <= 1'b0;
      busy_o <= 1'b0;
      done_o <= 1'b1;
      state <= IDLE;
    end else begin
      phase_o <= acc + poff;
      valid_o <= 1'b1;
      busy_o <= 1'b1;
      acc <= acc + freq;
      freq <= freq + step;
      if (cnt != '0) cnt <= cnt - CNT_BITS'(1);
      done_o <= cnt == CNT_BITS'(1);
      if (cnt == CNT_BITS'(1)) state <= IDLE;
    end
endmodule

// File: tb/tb_nco_phase_sweep.sv
// tb_nco_phase_sweep: scoreboard bench comparing phase words against the closed-form sample formula
module tb_nco_phase_sweep;
  localparam int PB = 47;
  localparam int CB = 32;
  logic clk = 1'b0, resetn = 1'b0, start_i = 1'b0, stop_i = 1'b0;
  logic [PB-1:0] ftw_i = '0, step_i = '0, poff_i = '0;
  logic [CB-1:0] nsamp_i = '0;
  logic valid_o, busy_o, done_o;
  logic [PB-1:0] phase_o;
  logic [PB-1:0] q[$];
  int total = 0, bad = 0;
  nco_phase_sweep dut (
    .clk(clk), .resetn(resetn), .start_i(start_i), .stop_i(stop_i),
    .ftw_i(ftw_i), .step_i(step_i), .poff_i(poff_i), .nsamp_i(nsamp_i),
    .valid_o(valid_o), .phase_o(phase_o), .busy_o(busy_o), .done_o(done_o)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic logic [PB-1:0] model(input logic [PB-1:0] f, input logic [PB-1:0] s,
                                          input logic [PB-1:0] p, input int k);
    logic [PB-1:0] kk, tri_n;
    kk = PB'(k);
    tri_n = PB'(k * (k - 1) / 2);
    return p + f * kk + s * tri_n;
  endfunction
  // scoreboard: every valid sample must match the oldest expected word
  always @(negedge clk)
    if (resetn && valid_o) begin
      if (q.size() == 0) chk("extra_sample", 1, 0);
      else chk("phase", phase_o, q.pop_front());
    end
  task automatic launch(input logic [PB-1:0] f, input logic [PB-1:0] s, input logic [PB-1:0] p,
                        input logic [CB-1:0] n, input int npush);
    for (int k = 0; k < npush; k++) q.push_back(model(f, s, p, k));
    @(negedge clk);
    ftw_i = f; step_i = s; poff_i = p; nsamp_i = n; start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0; ftw_i = '0; step_i = '0; poff_i = '0; nsamp_i = '0;
    chk("start_latency", valid_o, 0);
  endtask
  task automatic run(input logic [PB-1:0] f, input logic [PB-1:0] s, input logic [PB-1:0] p, input int n);
    int cnt = 0;
    bit fin = 0;
    launch(f, s, p, CB'(n), n);
    for (int i = 0; i < n + 5 && !fin; i++) begin
      @(negedge clk);
      if (valid_o) begin
        cnt++;
        chk("busy_run", busy_o, 1);
      end
      if (done_o) begin
        fin = 1;
        chk("done_count", cnt, n);
        chk("done_valid", valid_o, 1);
      end
    end
    if (!fin) chk("done_timeout", 0, 1);
    @(negedge clk);
    chk("after_valid", valid_o, 0);
    chk("after_busy", busy_o, 0);
    chk("after_done", done_o, 0);
    chk("queue_empty", q.size(), 0);
  endtask
  initial begin
    int nv;
    start_i = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_valid", valid_o, 0);
    chk("rst_phase", phase_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_done", done_o, 0);
    start_i = 1'b0;
    resetn = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_valid", valid_o, 0);
    chk("idle_busy", busy_o, 0);
    run(PB'(1) << 40, '0, '0, 4);
    run(PB'(1) << 46, '0, (PB'(1) << 46) + PB'(5), 3);
    run(PB'(1), PB'(2), '0, 5);
    run(PB'(2), '1, '0, 4);
    launch(PB'(3), '0, '0, '0, 10);
    nv = 0;
    for (int i = 0; i < 30 && nv < 10; i++) begin
      @(negedge clk);
      if (valid_o) nv++;
    end
    chk("cont_samples", nv, 10);
    stop_i = 1'b1;
    @(negedge clk);
    stop_i = 1'b0;
    chk("abort_valid", valid_o, 0);
    chk("abort_done", done_o, 1);
    chk("abort_busy", busy_o, 0);
    @(negedge clk);
    chk("abort_done_clear", done_o, 0);
    chk("abort_queue", q.size(), 0);
    start_i = 1'b1; stop_i = 1'b1; ftw_i = PB'(9); nsamp_i = CB'(2);
    @(negedge clk);
    start_i = 1'b0; stop_i = 1'b0;
    repeat (3) @(negedge clk);
    chk("startstop_busy", busy_o, 0);
    chk("startstop_valid", valid_o, 0);
    launch(PB'(5), '0, '0, CB'(8), 8);
    nv = 0;
    for (int i = 0; i < 20 && nv < 3; i++) begin
      @(negedge clk);
      if (valid_o) nv++;
    end
    chk("midrun_samples", nv, 3);
    resetn = 1'b0;
    #1;
    chk("midrst_valid", valid_o, 0);
    chk("midrst_phase", phase_o, 0);
    chk("midrst_busy", busy_o, 0);
    chk("midrst_done", done_o, 0);
    q.delete();
    @(negedge clk);
    resetn = 1'b1;
    run(PB'(7), '0, '0, 2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/nco_phase_sweep.md
# nco_phase_sweep

Phase generator that feeds the quadratic sine evaluator. It produces one PHASE_BITS-wide phase word per cycle with a valid strobe. The word comes from a modulo-2^PHASE_BITS accumulator with a constant offset and an optional linear frequency sweep (chirp). Runs are either a programmed number of samples or continuous until stopped. `valid_o`/`phase_o` connect directly to the evaluator's `valid_i`/`phase` inputs, which have no backpressure.

## Interface
- PHASE_BITS, 47, width of phase, tuning word, sweep step and offset
- CNT_BITS, 32, width of sample counter
- clk  in  1  clock
- resetn  in  1  reset, asynchronous, active-low
- start_i  in  1  start a run; sampled only in IDLE
- stop_i  in  1  abort a run; overrides start_i
- ftw_i  in  PHASE_BITS  initial frequency tuning word, unsigned
- step_i  in  PHASE_BITS  per-sample FTW increment, two's complement
- poff_i  in  PHASE_BITS  phase offset added to accumulator output
- nsamp_i  in  CNT_BITS  samples per run; 0 = continuous
- valid_o  out  1  phase_o valid this cycle
- phase_o  out  PHASE_BITS  phase word
- busy_o  out  1  run in progress
- done_o  out  1  one-cycle run-end pulse

## Operation
- States: IDLE, RUN.
- IDLE → RUN on an edge where start_i=1 and stop_i=0.
  - On that edge, latch ftw_i→freq, step_i→step, poff_i→poff, nsamp_i→cnt; clear acc to 0.
- start_i=1 with stop_i=1 in IDLE: ignored, stays IDLE.
- start_i in RUN: ignored. Config inputs in RUN: ignored.
- RUN, every edge:
  - phase_o ← acc+poff
  - valid_o ← 1
  - acc ← acc+freq
  - freq ← freq+step
  - if cnt≠0: cnt ← cnt−1
- Sample k (k=0,1,…) = poff + k·ftw + step·k(k−1)/2 mod 2^PHASE_BITS.
- All adds are PHASE_BITS wide. Carries are discarded; acc, freq and phase wrap silently. A negative step makes freq decrease and wrap below 0.
- Counted run (latched nsamp≠0): the edge issuing the sample when cnt=1 also sets done_o←1 and returns to IDLE. Exactly nsamp samples are issued.
- Continuous run (nsamp=0): cnt stays 0 and there is no self-termination.
- stop_i=1 sampled in RUN: no sample is issued on that edge. valid_o←0, done_o←1, busy_o←0, → IDLE.
- Outputs in IDLE: valid_o=0, done_o=0 except the single end pulse, busy_o=0. phase_o holds its last value.
- Reset (async, any time, including mid-run): state=IDLE, valid_o=0, phase_o=0, busy_o=0, done_o=0, acc=freq=step=poff=cnt=0. The first start after release behaves as after power-up.

## Timing
- All outputs are registered. No combinational path from inputs to outputs.
- Start latency: start_i sampled at edge T → first valid_o=1 after edge T+1, with phase_o=poff.
- Throughput: one sample per cycle, no gaps, for the whole run.
- busy_o is high from edge T+1 through the last valid sample inclusive.
- Counted completion: done_o=1 in the same cycle as the final valid_o=1. The next cycle has valid_o=0, busy_o=0, done_o=0.
- Abort: stop_i sampled at edge S → after S, valid_o=0, done_o=1 for one cycle, busy_o=0. Samples after edge S−1 are never issued.
- Back-to-back runs: start_i may be high during the done_o cycle (IDLE by then). The next run's first sample follows one cycle later, giving a one-cycle valid gap.
- Sample order is strictly in order, with no drop and no duplicate.

## Test plan
- Reset: hold resetn=0 with start_i=1 → valid_o=0, phase_o=0, busy_o=0, done_o=0. After release, start_i=0 → outputs unchanged.
- Constant tone: ftw=2^40, step=0, poff=0, nsamp=4 → phase_o = 0, 2^40, 2^41, 3·2^40 on consecutive cycles, done_o with the 4th, then valid_o=0.
- Wrap: ftw=2^46, poff=2^46+5, nsamp=3 → phase_o = 2^46+5, 5, 2^46+5.
- Chirp: ftw=1, step=2, poff=0, nsamp=5 → phase_o = 0,1,4,9,16. Step=−1 (all ones), ftw=2, nsamp=4 → 0,2,3,3.
- Continuous/abort: nsamp=0, stop_i after 10 valid samples → exactly 10 samples 0..9·ftw, done_o one cycle with valid_o=0. start_i with stop_i in IDLE → no run.
- Reset mid-run: drop resetn after 3 samples of nsamp=8 → outputs clear immediately. A restart with ftw=7, nsamp=2 → phase_o=0,7.
